// File: rtl/simmem_mem_responder.sv
// Behavioural AXI-style memory responder: queues AR/AW requests and answers with
// R bursts and B responses after fixed latencies; read and write paths are independent.

module simmem_req_fifo #(
  parameter int unsigned Width = 4,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wptr_reg;
  logic [PtrW-1:0]  rptr_reg;
  logic [CntW-1:0]  cnt_reg;

  assign full_o  = (cnt_reg == CntW'(Depth));
  assign empty_o = (cnt_reg == '0);
  // Head is read combinationally so the FSM sees it the cycle it arrives.
  assign head_o  = mem[rptr_reg];

  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem[wptr_reg] <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_reg <= '0;
      rptr_reg <= '0;
      cnt_reg  <= '0;
    end else begin
      if (push_i) wptr_reg <= wptr_reg + PtrW'(1);
      if (pop_i)  rptr_reg <= rptr_reg + PtrW'(1);
      if (push_i && !pop_i) begin
        cnt_reg <= cnt_reg + CntW'(1);
      end else if (!push_i && pop_i) begin
        cnt_reg <= cnt_reg - CntW'(1);
      end
    end
  end
endmodule

module simmem_mem_responder #(
  parameter int unsigned IdWidth       = 4,
  parameter int unsigned BurstLenWidth = 8,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned ReqQueueDepth = 4,
  parameter int unsigned RLatency      = 3,
  parameter int unsigned BLatency      = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [IdWidth-1:0]       ar_id_i,
  input  logic [BurstLenWidth-1:0] ar_len_i,
  input  logic                     ar_valid_i,
  output logic                     ar_ready_o,
  input  logic [IdWidth-1:0]       aw_id_i,
  input  logic                     aw_valid_i,
  output logic                     aw_ready_o,
  input  logic                     w_last_i,
  input  logic                     w_valid_i,
  output logic                     w_ready_o,
  output logic [IdWidth-1:0]       r_id_o,
  output logic [DataWidth-1:0]     r_data_o,
  output logic                     r_last_o,
  output logic                     r_valid_o,
  input  logic                     r_ready_i,
  output logic [IdWidth-1:0]       b_id_o,
  output logic [1:0]               b_resp_o,
  output logic                     b_valid_o,
  input  logic                     b_ready_i
);
  localparam int unsigned SerW  = DataWidth - 8;
  localparam int unsigned RLatW = $clog2(RLatency + 1);
  localparam int unsigned BLatW = $clog2(BLatency + 1);
  localparam logic [1:0]  RespOkay = 2'b00;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT, W_RESP} w_state_e;

  // Request queues
  logic                             ar_full, ar_empty, ar_push, ar_pop;
  logic [IdWidth+BurstLenWidth-1:0] ar_head;
  logic [IdWidth-1:0]               ar_head_id;
  logic [BurstLenWidth-1:0]         ar_head_len;
  logic                             aw_full, aw_empty, aw_push, aw_pop;
  logic [IdWidth-1:0]               aw_head_id;

  assign ar_push = ar_valid_i && !ar_full;
  assign aw_push = aw_valid_i && !aw_full;
  assign ar_ready_o = !ar_full;
  assign aw_ready_o = !aw_full;
  assign {ar_head_id, ar_head_len} = ar_head;

  simmem_req_fifo #(.Width(IdWidth + BurstLenWidth), .Depth(ReqQueueDepth)) u_ar_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (ar_push),
    .data_i  ({ar_id_i, ar_len_i}),
    .pop_i   (ar_pop),
    .head_o  (ar_head),
    .full_o  (ar_full),
    .empty_o (ar_empty)
  );

  simmem_req_fifo #(.Width(IdWidth), .Depth(ReqQueueDepth)) u_aw_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (aw_push),
    .data_i  (aw_id_i),
    .pop_i   (aw_pop),
    .head_o  (aw_head_id),
    .full_o  (aw_full),
    .empty_o (aw_empty)
  );

  // Read path
  r_state_e                 r_state_reg, r_state_next;
  logic [RLatW-1:0]         r_lat_reg, r_lat_next;
  logic [BurstLenWidth-1:0] r_beat_reg, r_beat_next;
  logic [SerW-1:0]          r_serial_reg, r_serial_next;
  logic                     r_is_last;
  logic [7:0]               r_beat_lo;

  assign r_is_last = (r_beat_reg == ar_head_len);
  assign r_beat_lo = 8'(r_beat_reg);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state_reg  <= R_IDLE;
      r_lat_reg    <= '0;
      r_beat_reg   <= '0;
      r_serial_reg <= '0;
    end else begin
      r_state_reg  <= r_state_next;
      r_lat_reg    <= r_lat_next;
      r_beat_reg   <= r_beat_next;
      r_serial_reg <= r_serial_next;
    end
  end

  always_comb begin
    r_state_next  = r_state_reg;
    r_lat_next    = r_lat_reg;
    r_beat_next   = r_beat_reg;
    r_serial_next = r_serial_reg;
    ar_pop        = 1'b0;
    case (r_state_reg)
      R_IDLE: begin
        if (!ar_empty) begin
          r_beat_next = '0;
          // The idle cycle counts toward the latency, so the wait state lasts RLatency-1 cycles.
          if (RLatency == 1) begin
            r_state_next = R_BURST;
          end else begin
            r_lat_next   = RLatW'(RLatency - 1);
            r_state_next = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        r_lat_next = r_lat_reg - RLatW'(1);
        if (r_lat_reg == RLatW'(1)) r_state_next = R_BURST;
      end
      R_BURST: begin
        if (r_ready_i) begin
          if (r_is_last) begin
            ar_pop        = 1'b1;
            r_serial_next = r_serial_reg + SerW'(1);
            r_state_next  = R_IDLE;
          end else begin
            r_beat_next = r_beat_reg + BurstLenWidth'(1);
          end
        end
      end
      default: r_state_next = R_IDLE;
    endcase
  end

  assign r_valid_o = (r_state_reg == R_BURST);
  assign r_id_o    = r_valid_o ? ar_head_id : '0;
  assign r_data_o  = r_valid_o ? {r_serial_reg, r_beat_lo} : '0;
  assign r_last_o  = r_valid_o && r_is_last;

  // Write path
  w_state_e         w_state_reg, w_state_next;
  logic [BLatW-1:0] b_lat_reg, b_lat_next;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_state_reg <= W_IDLE;
      b_lat_reg   <= '0;
    end else begin
      w_state_reg <= w_state_next;
      b_lat_reg   <= b_lat_next;
    end
  end

  always_comb begin
    w_state_next = w_state_reg;
    b_lat_next   = b_lat_reg;
    aw_pop       = 1'b0;
    case (w_state_reg)
      W_IDLE: begin
        if (!aw_empty) w_state_next = W_DATA;
      end
      W_DATA: begin
        if (w_valid_i && w_last_i) begin
          if (BLatency == 1) begin
            w_state_next = W_RESP;
          end else begin
            b_lat_next   = BLatW'(BLatency - 1);
            w_state_next = W_WAIT;
          end
        end
      end
      W_WAIT: begin
        b_lat_next = b_lat_reg - BLatW'(1);
        if (b_lat_reg == BLatW'(1)) w_state_next = W_RESP;
      end
      W_RESP: begin
        if (b_ready_i) begin
          aw_pop       = 1'b1;
          w_state_next = W_IDLE;
        end
      end
      default: w_state_next = W_IDLE;
    endcase
  end

  assign w_ready_o = (w_state_reg == W_DATA);
  assign b_valid_o = (w_state_reg == W_RESP);
  assign b_id_o    = b_valid_o ? aw_head_id : '0;
  assign b_resp_o  = RespOkay;
endmodule
